// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Byte-oriented 8N1 UART transmitter with a small input FIFO. Bytes written by
// the fabric are queued, then serialised LSB-first on o_TX_Serial as
// start bit, 8 data bits, stop bit, each bit held CLKS_PER_BIT clocks.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// (XOR of the 8 data bits) between data bit 7 and the stop bit.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   FIFO_DEPTH    transmit buffer depth in bytes (power of 2, >= 2)
//
// Ports
//   i_Clock      system clock, rising edge
//   reset        synchronous, active-low reset (0 = reset)
//   i_TX_DV      write strobe
//   i_TX_Byte    byte to transmit, sampled with i_TX_DV
//   o_TX_Ready   FIFO not full (registered)
//   o_TX_Active  high while a frame is on the line (start through stop)
//   o_TX_Serial  serial line, idle high (registered)
//   o_TX_Done    one-cycle pulse after each stop bit completes
//
// Handshake: a byte is taken on a rising edge where i_TX_DV=1 and either
// o_TX_Ready=1 or the FIFO head is popped on that same edge (a write that
// coincides with a pop keeps a full FIFO full). Any other write is dropped.
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       i_Clock,
   input  logic       reset,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Ready,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] FULL    = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
`ifdef UART_TX_PARITY_EN
      ST_CLEANUP = 3'd4,
      ST_PARITY  = 3'd5
`else
      ST_CLEANUP = 3'd4
`endif
   } state_e;

   // FSM state and datapath registers
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;

   // FIFO registers
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]   count_q, count_d;
   logic            ready_q, ready_d;

   // Registered outputs
   logic            serial_q, serial_d;
   logic            active_q, active_d;
   logic            done_q, done_d;

   logic            pop;
   logic            wr_en;
   logic            tick;
   logic [CW-1:0]   cnt_next;

   // ---------------------------------------------------------------------------
   // FIFO control. The head is only popped from IDLE, so the byte in flight
   // lives in shift_q and later writes cannot disturb it.
   // ---------------------------------------------------------------------------
   always_comb begin
      pop      = (state_q == ST_IDLE) && (count_q != '0);
      wr_en    = i_TX_DV && (ready_q || pop);
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + NW'(1);
         2'b01:   count_d = count_q - NW'(1);
         default: count_d = count_q;
      endcase
      ready_d = (count_d != FULL);
   end

   // ---------------------------------------------------------------------------
   // Process 1: state register (plus datapath, FIFO and output registers)
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_Clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge i_Clock) begin
      if (reset && wr_en) begin
         mem_q[wr_ptr_q] <= i_TX_Byte;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tick     = (cnt_q == CNT_MAX);
      cnt_next = tick ? '0 : cnt_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d = cnt_next;
            if (tick) begin
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            cnt_d = cnt_next;
            if (tick) begin
               if (idx_q == 3'd7) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            cnt_d = cnt_next;
            if (tick) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            cnt_d = cnt_next;
            if (tick) begin
               state_d = ST_CLEANUP;
            end
         end
         ST_CLEANUP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Process 3: output logic. Outputs are registered, so the line follows the
   // state by one clock; that uniform lag gives the write-to-start latency of
   // two edges and the stop + CLEANUP + IDLE gap between back-to-back frames.
   // ---------------------------------------------------------------------------
   always_comb begin
      serial_d = 1'b1;
      active_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_START: begin
            serial_d = 1'b0;
            active_d = 1'b1;
         end
         ST_DATA: begin
            serial_d = shift_q[idx_q];
            active_d = 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            serial_d = ^shift_q;
            active_d = 1'b1;
         end
`endif
         ST_STOP: begin
            serial_d = 1'b1;
            active_d = 1'b1;
         end
         ST_CLEANUP: begin
            done_d = 1'b1;
         end
         default: begin
            serial_d = 1'b1;
         end
      endcase
   end

   assign o_TX_Ready  = ready_q;
   assign o_TX_Active = active_q;
   assign o_TX_Serial = serial_q;
   assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Table of single-byte frames with hand-computed line patterns checked cycle by
// cycle, plus hand-written sequences: burst fill, write+pop while full, reset
// mid-frame and a streamed wrap-around run. A line monitor decodes every frame
// and checks it against the expected byte queue.
// -----------------------------------------------------------------------------
module tb_uart_tx;
   localparam int C = 4;
   localparam int D = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   // clock / reset
   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv;
   logic [7:0] din;
   logic       o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .i_Clock    (clk),
      .reset      (rst_n),
      .i_TX_DV    (dv),
      .i_TX_Byte  (din),
      .o_TX_Ready (o_TX_Ready),
      .o_TX_Active(o_TX_Active),
      .o_TX_Serial(o_TX_Serial),
      .o_TX_Done  (o_TX_Done)
   );

   // scoreboard
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         gap_q[$];

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame: line bits in time order, bit 0 = start, bits 1..8 = data, bit 9 = stop
   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   vec_t vecs[7];

   function automatic logic exp_bit(input vec_t v, input int j);
      if (j < 9) return v.frame[j];
`ifdef UART_TX_PARITY_EN
      if (j == 9) return v.par;
      return 1'b1;
`else
      return v.frame[9];
`endif
   endfunction

   // line monitor: decodes frames at mid-bit, checks framing and byte order
   initial begin : monitor
      int         high_run;
      bit         aborted;
      logic [NB-1:0] samp;
      logic [7:0] b;
      high_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            high_run = 0;
         end else if (o_TX_Serial) begin
            high_run++;
         end else begin
            gap_q.push_back(high_run);
            aborted = 0;
            samp    = '0;
            for (int k = 1; k < NB * C; k++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1;
                  break;
               end
               if (k % C == C / 2) samp[k / C] = o_TX_Serial;
            end
            if (aborted) begin
               high_run = 0;
            end else begin
               high_run = C;
               b = samp[8:1];
               chk_b("mon_start", samp[0], 1'b0);
               chk_b("mon_stop", samp[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
               chk_b("mon_parity", samp[9], ^b);
`endif
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL mon_stray: got %0h expected no byte at %0t", b, $time);
               end else begin
                  chk_i("mon_byte", int'(b), int'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // driver tasks
   task automatic run_vector(input vec_t v);
      @(negedge clk);
      dv  = 1'b1;
      din = v.data;
      exp_q.push_back(v.data);
      @(negedge clk);               // write edge N has passed
      dv = 1'b0;
      chk_b("vec_ready", o_TX_Ready, 1'b1);
      chk_b("vec_line_n", o_TX_Serial, 1'b1);
      @(negedge clk);               // edge N+1: still idle high
      chk_b("vec_line_n1", o_TX_Serial, 1'b1);
      for (int k = 0; k <= NB * C + 1; k++) begin
         @(negedge clk);            // edge N+2+k
         chk_b("vec_serial", o_TX_Serial, (k < NB * C) ? exp_bit(v, k / C) : 1'b1);
         chk_b("vec_active", o_TX_Active, (k < NB * C) ? 1'b1 : 1'b0);
         chk_b("vec_done", o_TX_Done, (k == NB * C) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic wait_drain(input int limit);
      bit ok;
      ok = 0;
      for (int t = 0; t < limit; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !o_TX_Active) begin
            ok = 1;
            break;
         end
      end
      chk_b("drain", ok, 1'b1);
   endtask

   // writes bytes on consecutive edges; ready after each edge vs exp_rdy
   task automatic write_burst(input logic [7:0] b0, input int n, input logic [7:0] exp_rdy,
                              input int n_keep, input string name);
      @(negedge clk);
      dv  = 1'b1;
      din = b0;
      exp_q.push_back(b0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_b(name, o_TX_Ready, exp_rdy[i]);
         if (i < n - 1) begin
            din = b0 + 8'(i + 1);
            if (i + 1 < n_keep) exp_q.push_back(din);
         end else begin
            dv = 1'b0;
         end
      end
   endtask

   initial begin
      int  bad;
      int  next;
      bit  seen;

      vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
      vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
      vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
      vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
      vecs[4] = '{8'h07, 10'b1000001110, 1'b1};
      vecs[5] = '{8'h03, 10'b1000000110, 1'b0};
      vecs[6] = '{8'h80, 10'b1100000000, 1'b1};

      // reset state
      rst_n = 1'b0;
      dv    = 1'b0;
      din   = 8'h00;
      repeat (3) @(negedge clk);
      chk_b("rst_serial", o_TX_Serial, 1'b1);
      chk_b("rst_ready", o_TX_Ready, 1'b1);
      chk_b("rst_active", o_TX_Active, 1'b0);
      chk_b("rst_done", o_TX_Done, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven single frames
      for (int i = 0; i < 7; i++) run_vector(vecs[i]);

      // burst fill: 0x01..0x06, 0x06 dropped once full
      gap_q.delete();
      write_burst(8'h01, 6, 8'b0011_0000 ^ 8'b0011_1111, 5, "burst_ready");
      wait_drain(2000);
      chk_i("burst_frames", gap_q.size(), 5);
      for (int i = 1; i < gap_q.size(); i++) chk_i("burst_gap", gap_q[i], C + 2);

      // write and pop on the same edge while full
      write_burst(8'hA1, 5, 8'b1111_0000 ^ 8'b1111_1111, 5, "full_ready");
      seen = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (o_TX_Done) begin
            seen = 1;
            break;
         end
      end
      chk_b("full_done_seen", seen, 1'b1);
      chk_b("full_ready_before", o_TX_Ready, 1'b0);
      dv  = 1'b1;
      din = 8'hB6;
      exp_q.push_back(8'hB6);
      @(negedge clk);
      dv = 1'b0;
      chk_b("full_wr_pop_ready", o_TX_Ready, 1'b0);
      @(negedge clk);
      chk_b("full_ready_hold", o_TX_Ready, 1'b0);
      wait_drain(3000);

      // reset mid data bit of 0x3C with two bytes queued
      write_burst(8'h3C, 3, 8'b1111_1111, 3, "rst_q_ready");
      repeat (C + 5) @(negedge clk);
      chk_b("rst_mid_active", o_TX_Active, 1'b1);
      chk_b("rst_mid_serial", o_TX_Serial, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk_b("rst_mid_serial_hi", o_TX_Serial, 1'b1);
      chk_b("rst_mid_active_lo", o_TX_Active, 1'b0);
      chk_b("rst_mid_ready", o_TX_Ready, 1'b1);
      chk_b("rst_mid_done", o_TX_Done, 1'b0);
      exp_q.delete();
      rst_n = 1'b1;
      bad = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (!o_TX_Serial || o_TX_Active) bad++;
      end
      chk_i("quiet_after_reset", bad, 0);
      @(negedge clk);
      dv  = 1'b1;
      din = 8'h5A;
      exp_q.push_back(8'h5A);
      @(negedge clk);
      dv = 1'b0;
      wait_drain(500);

      // wrap-around: stream 0x00..0x09 whenever ready
      next = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         dv = 1'b0;
         if (next == 10) break;
         if (o_TX_Ready) begin
            dv  = 1'b1;
            din = 8'(next);
            exp_q.push_back(8'(next));
            next++;
         end
      end
      dv = 1'b0;
      chk_i("wrap_written", next, 10);
      wait_drain(3000);
      chk_b("wrap_ready_end", o_TX_Ready, 1'b1);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
